channel_update_scheduler: RTL and testbench

//  Clocked scheduler that time-shares one PWL section evaluator among the NSEC pole sections of a channel model.
//  Per-section step timers decide when each section is re-evaluated. An input event forces every section to restart.

---
 rtl/channel_sched_pkg.sv | 10 +
 rtl/rr_pick.sv | 27 ++
 rtl/channel_update_scheduler.sv | 103 ++++++++++
 tb/tb_channel_update_scheduler.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/channel_sched_pkg.sv
// channel_sched_pkg: scheduler state encoding, default widths and the step clamp
// shared by the channel update scheduler and its testbench-visible parameters.
package channel_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;
  localparam int NSEC_DEF = 4;
  localparam int DTW_DEF = 16;
  function automatic int unsigned clamp(input int unsigned v, input int unsigned lo, input int unsigned hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin select over a request vector, searching from last+1 and wrapping;
// returns a one-hot grant and the granted index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    // Walk from the farthest candidate back to the nearest so the nearest wins.
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last) + k) % N);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/channel_update_scheduler.sv
// channel_update_scheduler: time-shares one PWL section evaluator among NSEC pole sections,
// driven by per-section step timers and forced restarts on input events.
module channel_update_scheduler
  import channel_sched_pkg::*;
#(
  parameter int          NSEC   = NSEC_DEF,
  parameter int          SECW   = $clog2(NSEC),
  parameter int          DTW    = DTW_DEF,
  parameter int unsigned DT_MIN = 1,
  parameter int unsigned DT_MAX = 65535
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_evt,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [SECW-1:0] req_sec,
  output logic            req_restart,
  input  logic            eval_done,
  input  logic [DTW-1:0]  eval_dt,
  output logic            so_update,
  output logic            busy
);
  state_t state_q, state_d;
  logic [NSEC-1:0] pend_q, pend_d, rst_flag_q, rst_flag_d, gnt;
  logic [DTW-1:0] timer_q [NSEC];
  logic [DTW-1:0] timer_d [NSEC];
  logic [SECW-1:0] last_q, last_d, sel_q, sel_d, pick;
  logic valid_q, valid_d, restart_q, restart_d, so_q, so_d, busy_q, busy_d;
  logic grant, load, start;
  logic [DTW-1:0] dt_clamped;

  rr_pick #(.N(NSEC), .W(SECW)) u_pick (
    .req (pend_q),
    .last(last_q),
    .gnt (gnt),
    .idx (pick)
  );

  assign grant = state_q == ISSUE && valid_q && req_ready;
  assign load = state_q == WAIT && eval_done;
  assign start = state_q == IDLE && pend_q != '0;
  assign dt_clamped = DTW'(clamp(32'(eval_dt), DT_MIN, DT_MAX));

  // An event overrides every other update of a section in the same cycle.
  for (genvar i = 0; i < NSEC; i++) begin : g_sec
    logic mine;
    assign mine = sel_q == SECW'(i);
    assign timer_d[i] = in_evt ? '0 :
                        (load && mine) ? dt_clamped :
                        timer_q[i] != '0 ? timer_q[i] - DTW'(1) : timer_q[i];
    assign pend_d[i] = in_evt || timer_q[i] == DTW'(1) || (pend_q[i] && !(grant && mine));
    assign rst_flag_d[i] = in_evt || (rst_flag_q[i] && !(grant && mine));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pend_q <= '1;
      rst_flag_q <= '1;
      last_q <= SECW'(NSEC - 1);
      sel_q <= '0;
      valid_q <= 1'b0;
      restart_q <= 1'b0;
      so_q <= 1'b0;
      busy_q <= 1'b0;
      for (int k = 0; k < NSEC; k++) timer_q[k] <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      rst_flag_q <= rst_flag_d;
      last_q <= last_d;
      sel_q <= sel_d;
      valid_q <= valid_d;
      restart_q <= restart_d;
      so_q <= so_d;
      busy_q <= busy_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q == IDLE  ? (start ? ISSUE : IDLE) :
              state_q == ISSUE ? (grant ? WAIT : ISSUE) :
              state_q == WAIT  ? (eval_done ? COMMIT : WAIT) : IDLE;
  end

  // busy is registered from next-state values so it reads 0 while held in reset.
  always_comb begin
    valid_d = start || (state_q == ISSUE && !grant);
    sel_d = start ? pick : sel_q;
    restart_d = start ? |(gnt & rst_flag_q) : restart_q;
    last_d = grant ? sel_q : last_q;
    so_d = state_q == COMMIT && pend_q == '0;
    busy_d = pend_d != '0 || state_d != IDLE;
  end

  assign req_valid = valid_q;
  assign req_sec = sel_q;
  assign req_restart = restart_q;
  assign so_update = so_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_channel_update_scheduler.sv
// tb_channel_update_scheduler: randomized bench with a deadline-based reference model
// of the scheduler; the bench also plays the evaluator.
module tb_channel_update_scheduler;
  logic clk = 1'b0, rstn = 1'b0, in_evt = 1'b0, req_ready = 1'b0, eval_done = 1'b0;
  logic [15:0] eval_dt = '0;
  logic req_valid, req_restart, so_update, busy;
  logic [1:0] req_sec;

  always #5 clk = ~clk;

  channel_update_scheduler #(.NSEC(4), .SECW(2), .DTW(16), .DT_MIN(1), .DT_MAX(1000)) dut (
    .clk(clk), .rstn(rstn), .in_evt(in_evt), .req_valid(req_valid), .req_ready(req_ready),
    .req_sec(req_sec), .req_restart(req_restart), .eval_done(eval_done), .eval_dt(eval_dt),
    .so_update(so_update), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: sections carry an absolute expiry edge instead of a countdown.
  bit [3:0] m_pend, m_rst;
  int m_dl [4];
  int m_ph, m_sel, m_last, m_lat, k;
  bit m_valid, m_restart, m_so, m_fresh;
  int p_ready, p_evt, p_stray, lat_lo, lat_hi;
  bit dt_ten, force_evt;

  function automatic int clampm(input int v);
    return v < 1 ? 1 : (v > 1000 ? 1000 : v);
  endfunction

  function automatic logic [15:0] pick_dt();
    int r;
    if (dt_ten) return 16'd10;
    r = $urandom_range(0, 49);
    return r == 0 ? 16'hffff : r == 1 ? 16'd0 : r == 2 ? 16'($urandom_range(1001, 65534)) :
           16'($urandom_range(1, 15));
  endfunction

  task automatic model_reset();
    m_pend = 4'hf;
    m_rst = 4'hf;
    foreach (m_dl[i]) m_dl[i] = -1;
    m_ph = 0; m_sel = 0; m_last = 3; m_lat = 0; k = 0;
    m_valid = 0; m_restart = 0; m_so = 0; m_fresh = 1;
  endtask

  task automatic model_edge();
    bit any;
    any = m_pend != 0;
    m_so = m_ph == 3 && !any;
    k++;
    case (m_ph)
      0: if (any) begin
        for (int d = 1; d <= 4; d++)
          if (m_pend[(m_last + d) % 4]) begin m_sel = (m_last + d) % 4; break; end
        m_restart = m_rst[m_sel];
        m_valid = 1;
        m_ph = 1;
      end
      1: if (req_ready) begin
        m_valid = 0;
        m_pend[m_sel] = 0;
        m_rst[m_sel] = 0;
        m_last = m_sel;
        m_ph = 2;
        m_lat = $urandom_range(lat_lo, lat_hi);
      end
      2: if (eval_done) begin
        if (!in_evt) m_dl[m_sel] = k + clampm(int'(eval_dt));
        m_ph = 3;
      end
      default: m_ph = 0;
    endcase
    foreach (m_dl[i]) if (m_dl[i] == k) begin m_pend[i] = 1; m_dl[i] = -1; end
    if (in_evt) begin
      m_pend = 4'hf;
      m_rst = 4'hf;
      foreach (m_dl[i]) m_dl[i] = -1;
    end
    m_fresh = 0;
  endtask

  task automatic drive();
    if (force_evt && m_ph == 2) begin in_evt = 1; force_evt = 0; end
    else in_evt = $urandom_range(0, 999) < p_evt;
    req_ready = $urandom_range(0, 99) < p_ready;
    if (m_ph == 2) begin
      eval_done = m_lat == 0;
      eval_dt = m_lat == 0 ? pick_dt() : 16'($urandom);
      if (m_lat > 0) m_lat--;
    end else begin
      eval_done = $urandom_range(0, 99) < p_stray;
      eval_dt = 16'($urandom);
    end
  endtask

  // Called at a negedge: compare, drive, take one edge, advance the model.
  task automatic step();
    chk("req_valid", req_valid, m_valid);
    if (m_valid) begin
      chk("req_sec", req_sec, m_sel);
      chk("req_restart", req_restart, m_restart);
    end
    chk("so_update", so_update, m_so);
    chk("busy", busy, m_fresh ? 0 : int'(m_pend != 0 || m_ph != 0));
    drive();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    p_ready = 100; p_evt = 0; p_stray = 0; lat_lo = 1; lat_hi = 1; dt_ten = 1; force_evt = 0;
    #1;
    chk("rst_valid", req_valid, 0);
    chk("rst_sec", req_sec, 0);
    chk("rst_restart", req_restart, 0);
    chk("rst_so", so_update, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    repeat (150) step();
    for (int i = 0; i < 50 && !m_valid; i++) step();
    chk("reach_req", m_valid, 1);
    p_ready = 0;
    repeat (5) step();
    p_ready = 100;
    repeat (20) step();
    p_ready = 65; p_evt = 15; p_stray = 10; lat_lo = 0; lat_hi = 3; dt_ten = 0;
    for (int r = 0; r < 6; r++) begin
      force_evt = 1;
      repeat (600) step();
    end
    p_ready = 100; p_evt = 0; p_stray = 0; lat_lo = 3; lat_hi = 3; dt_ten = 1; force_evt = 0;
    for (int i = 0; i < 200 && m_ph != 2; i++) step();
    chk("reach_wait", m_ph, 2);
    #2 rstn = 0;
    #1;
    chk("async_valid", req_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_so", so_update, 0);
    model_reset();
    @(negedge clk);
    rstn = 1;
    repeat (120) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
